// File: rtl/ucc_config_bank.sv
// Run-time programmable UCC region bank: shadow min/max pairs are written over the
// peripheral bus, validated on a keyed commit, then copied to the active outputs and locked.
//   state    | meaning
//   UNLOCKED | shadows writable, waiting for a keyed commit
//   VALIDATE | checking shadow_min[idx] <= shadow_max[idx], one region per cycle
//   LOCKED   | active pairs valid; bank frozen until reset
module ucc_config_bank #(
  parameter int unsigned N_UCC     = 3,
  parameter logic [13:0] BASE_ADDR = 14'h0C8,
  parameter logic [7:0]  CMD_KEY   = 8'hA5
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic [13:0]            per_addr,
  input  logic [15:0]            per_din,
  input  logic                   per_en,
  input  logic [1:0]             per_we,
  output logic [15:0]            per_dout,
  output logic [16*N_UCC-1:0]    ucc_min,
  output logic [16*N_UCC-1:0]    ucc_max,
  output logic                   ucc_valid
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_VALIDATE = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [13:0] LAST_OFF = 14'(2 * N_UCC);
  localparam logic [3:0]  LAST_IDX = 4'(N_UCC - 1);

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           err_idx_q, err_idx_d;
  logic                 range_err_q, range_err_d;
  logic                 key_err_q, key_err_d;
  logic                 wr_viol_q, wr_viol_d;
  logic [15:0]          shadow_min_q [N_UCC];
  logic [15:0]          shadow_min_d [N_UCC];
  logic [15:0]          shadow_max_q [N_UCC];
  logic [15:0]          shadow_max_d [N_UCC];
  logic [16*N_UCC-1:0]  act_min_q, act_min_d;
  logic [16*N_UCC-1:0]  act_max_q, act_max_d;

  logic [13:0]          off;
  logic                 sel, ctrl_hit, wr_acc, rd_acc, commit_ok;
  logic [N_UCC-1:0]     min_hit, max_hit;
  logic [15:0]          cur_min, cur_max, status;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  we);
    merge_bytes = {we[1] ? new_v[15:8] : old_v[15:8],
                   we[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

  // Address decode; addresses below BASE_ADDR wrap to a large offset and miss.
  always_comb begin
    off      = per_addr - BASE_ADDR;
    sel      = per_en && (off <= LAST_OFF);
    ctrl_hit = sel && (off == 14'd0);
    wr_acc   = sel && (per_we != 2'b00);
    rd_acc   = sel && (per_we == 2'b00);
    min_hit  = '0;
    max_hit  = '0;
    for (int i = 0; i < N_UCC; i++) begin
      min_hit[i] = sel && (off == 14'(2 * i + 1));
      max_hit[i] = sel && (off == 14'(2 * i + 2));
    end
    commit_ok = (per_we == 2'b11) && (per_din[15:8] == CMD_KEY) && per_din[0];
  end

  always_comb begin
    cur_min = '0;
    cur_max = '0;
    for (int i = 0; i < N_UCC; i++) begin
      if (idx_q == 4'(i)) begin
        cur_min = shadow_min_q[i];
        cur_max = shadow_max_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_idx_d    = err_idx_q;
    range_err_d  = range_err_q;
    key_err_d    = key_err_q;
    wr_viol_d    = wr_viol_q;
    shadow_min_d = shadow_min_q;
    shadow_max_d = shadow_max_q;
    act_min_d    = act_min_q;
    act_max_d    = act_max_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (wr_acc) begin
          for (int i = 0; i < N_UCC; i++) begin
            if (min_hit[i]) shadow_min_d[i] = merge_bytes(shadow_min_q[i], per_din, per_we);
            if (max_hit[i]) shadow_max_d[i] = merge_bytes(shadow_max_q[i], per_din, per_we);
          end
          if (ctrl_hit) begin
            if (commit_ok) begin
              range_err_d = 1'b0;
              key_err_d   = 1'b0;
              err_idx_d   = 4'd0;
              idx_d       = 4'd0;
              state_d     = ST_VALIDATE;
            end else begin
              key_err_d = 1'b1;
            end
          end
        end
      end
      ST_VALIDATE: begin
        if (cur_min > cur_max) begin
          range_err_d = 1'b1;
          err_idx_d   = idx_q;
          state_d     = ST_UNLOCKED;
        end else if (idx_q == LAST_IDX) begin
          // Copy every pair on the same edge that raises ucc_valid.
          for (int i = 0; i < N_UCC; i++) begin
            act_min_d[16*i +: 16] = shadow_min_q[i];
            act_max_d[16*i +: 16] = shadow_max_q[i];
          end
          state_d = ST_LOCKED;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_LOCKED: begin
        if (wr_acc) wr_viol_d = 1'b1;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_UNLOCKED;
      idx_q       <= 4'd0;
      err_idx_q   <= 4'd0;
      range_err_q <= 1'b0;
      key_err_q   <= 1'b0;
      wr_viol_q   <= 1'b0;
      act_min_q   <= '0;
      act_max_q   <= '0;
      for (int i = 0; i < N_UCC; i++) begin
        shadow_min_q[i] <= 16'd0;
        shadow_max_q[i] <= 16'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_idx_q    <= err_idx_d;
      range_err_q  <= range_err_d;
      key_err_q    <= key_err_d;
      wr_viol_q    <= wr_viol_d;
      act_min_q    <= act_min_d;
      act_max_q    <= act_max_d;
      shadow_min_q <= shadow_min_d;
      shadow_max_q <= shadow_max_d;
    end
  end

  assign status = {4'h0, err_idx_q, 3'b000, wr_viol_q, key_err_q, range_err_q,
                   (state_q == ST_VALIDATE), (state_q == ST_LOCKED)};

  always_comb begin
    per_dout = 16'd0;
    if (rd_acc) begin
      if (ctrl_hit) per_dout = status;
      for (int i = 0; i < N_UCC; i++) begin
        if (min_hit[i]) per_dout = shadow_min_q[i];
        if (max_hit[i]) per_dout = shadow_max_q[i];
      end
    end
  end

  assign ucc_min   = act_min_q;
  assign ucc_max   = act_max_q;
  assign ucc_valid = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ucc_config_bank.sv
// Bench for ucc_config_bank: directed scenarios plus a randomized bus mix, checked
// against a transaction-level model of the bank held in plain arrays.
module tb_ucc_config_bank;
  localparam int          N    = 3;
  localparam logic [13:0] BASE = 14'h0C8;
  localparam logic [7:0]  KEY  = 8'hA5;

  logic              mclk = 1'b0;
  logic              reset_n = 1'b0;
  logic [13:0]       per_addr = '0;
  logic [15:0]       per_din = '0;
  logic              per_en = 1'b0;
  logic [1:0]        per_we = 2'b00;
  logic [15:0]       per_dout;
  logic [16*N-1:0]   ucc_min, ucc_max;
  logic              ucc_valid;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] m_min [N];
  logic [15:0] m_max [N];
  logic [15:0] m_amin [N];
  logic [15:0] m_amax [N];
  bit          m_locked, m_range, m_key, m_viol;
  int          m_eidx;

  ucc_config_bank #(.N_UCC(N), .BASE_ADDR(BASE), .CMD_KEY(KEY)) dut (
    .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .ucc_min(ucc_min), .ucc_max(ucc_max), .ucc_valid(ucc_valid)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] m_status();
    return {4'h0, 4'(m_eidx), 3'b000, m_viol, m_key, m_range, 1'b0, m_locked};
  endfunction

  function automatic logic [16*N-1:0] pack_min();
    logic [16*N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[16*i +: 16] = m_amin[i];
    return v;
  endfunction

  function automatic logic [16*N-1:0] pack_max();
    logic [16*N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[16*i +: 16] = m_amax[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_min[i] = 0; m_max[i] = 0; m_amin[i] = 0; m_amax[i] = 0;
    end
    m_locked = 0; m_range = 0; m_key = 0; m_viol = 0; m_eidx = 0;
  endtask

  task automatic bus_wr(input logic [13:0] addr, input logic [15:0] d, input logic [1:0] we);
    @(negedge mclk);
    per_addr = addr; per_din = d; per_we = we; per_en = 1'b1;
    @(posedge mclk);
    #1 per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic bus_rd(input logic [13:0] addr, output logic [15:0] d);
    @(negedge mclk);
    per_addr = addr; per_we = 2'b00; per_en = 1'b1;
    #1 d = per_dout;
    #1 per_en = 1'b0;
  endtask

  task automatic write_region(input int r, input bit is_max, input logic [15:0] d, input logic [1:0] we);
    logic [15:0] mask;
    bus_wr(BASE + 14'(2 * r + 1 + int'(is_max)), d, we);
    mask = {we[1] ? 8'hFF : 8'h00, we[0] ? 8'hFF : 8'h00};
    if (m_locked) m_viol = 1;
    else if (is_max) m_max[r] = (m_max[r] & ~mask) | (d & mask);
    else m_min[r] = (m_min[r] & ~mask) | (d & mask);
  endtask

  task automatic check_region(input int r, input bit is_max);
    logic [15:0] s;
    bus_rd(BASE + 14'(2 * r + 1 + int'(is_max)), s);
    check(is_max ? "shadow_max" : "shadow_min", s, is_max ? m_max[r] : m_min[r]);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] s;
    bus_rd(BASE, s);
    check({tag, "_status"}, s, m_status());
    check({tag, "_valid"}, ucc_valid, m_locked);
    check({tag, "_min"}, ucc_min, pack_min());
    check({tag, "_max"}, ucc_max, pack_max());
  endtask

  // Predicts the outcome of a CTRL write from the model's view of the regions.
  task automatic commit(input logic [15:0] d, input logic [1:0] we);
    logic [15:0] s;
    int fail, cyc;
    bit good;
    good = (we == 2'b11) && (d[15:8] == KEY) && d[0];
    if (m_locked) begin
      bus_wr(BASE, d, we);
      m_viol = 1;
      return;
    end
    if (!good) begin
      bus_wr(BASE, d, we);
      m_key = 1;
      return;
    end
    fail = -1;
    for (int i = N - 1; i >= 0; i--) if (m_min[i] > m_max[i]) fail = i;
    cyc = (fail < 0) ? N : fail + 1;
    bus_wr(BASE, d, we);
    m_range = 0; m_key = 0; m_eidx = 0;
    for (int k = 0; k < cyc; k++) begin
      bus_rd(BASE, s);
      check("busy", s[1], 1'b1);
      check("valid_early", ucc_valid, 1'b0);
    end
    @(posedge mclk);
    #1;
    if (fail < 0) begin
      m_locked = 1;
      for (int i = 0; i < N; i++) begin
        m_amin[i] = m_min[i]; m_amax[i] = m_max[i];
      end
    end else begin
      m_range = 1; m_eidx = fail;
    end
    check("commit_valid", ucc_valid, m_locked);
    bus_rd(BASE, s);
    check("commit_status", s, m_status());
  endtask

  task automatic apply_reset();
    logic [15:0] s;
    @(posedge mclk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_valid", ucc_valid, 1'b0);
    check("rst_min", ucc_min, '0);
    check("rst_max", ucc_max, '0);
    bus_rd(BASE, s);
    check("rst_status", s, 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] s, d;
    logic [1:0]  we;
    int op, r;
    model_reset();
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    check_all("reset");

    // Byte lanes on shadow_max[2]
    write_region(2, 1, 16'hAB12, 2'b01);
    bus_rd(BASE + 14'd6, s);
    check("lane_lo", s, 16'h0012);
    write_region(2, 1, 16'hCD00, 2'b10);
    bus_rd(BASE + 14'd6, s);
    check("lane_hi", s, 16'hCD12);

    // Range error at region 1
    write_region(0, 0, 16'h0100, 2'b11);
    write_region(0, 1, 16'h01FF, 2'b11);
    write_region(1, 0, 16'h0300, 2'b11);
    write_region(1, 1, 16'h02FF, 2'b11);
    write_region(2, 0, 16'hE000, 2'b11);
    write_region(2, 1, 16'hFFDF, 2'b11);
    commit(16'hA501, 2'b11);
    bus_rd(BASE, s);
    check("range_status", s, 16'h0104);
    check("range_min", ucc_min, '0);

    // Bad key
    commit(16'h5A01, 2'b11);
    bus_rd(BASE, s);
    check("key_err_bit", s[3], 1'b1);
    check("key_unlocked", s[0], 1'b0);

    // Good commit with region 1 at equality
    write_region(1, 0, 16'h0200, 2'b11);
    write_region(1, 1, 16'h0200, 2'b11);
    commit(16'hA501, 2'b11);
    check("good_min", ucc_min, 48'hE000_0200_0100);
    check("good_max", ucc_max, 48'hFFDF_0200_01FF);
    bus_rd(BASE, s);
    check("good_status", s, 16'h0001);

    // Lock violation
    write_region(0, 0, 16'h1234, 2'b11);
    check("lock_min", ucc_min, 48'hE000_0200_0100);
    bus_rd(BASE, s);
    check("wr_viol", s, 16'h0011);
    check_region(0, 0);
    commit(16'hA501, 2'b11);
    check_all("locked");
    apply_reset();
    check_all("post_reset");

    // Reset during the second VALIDATE cycle
    for (int i = 0; i < N; i++) begin
      write_region(i, 0, 16'(16'h1000 * (i + 1)), 2'b11);
      write_region(i, 1, 16'(16'h1000 * (i + 1) + 16'h10), 2'b11);
    end
    bus_wr(BASE, 16'hA501, 2'b11);
    @(posedge mclk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid", ucc_valid, 1'b0);
    check("abort_min", ucc_min, '0);
    check("abort_max", ucc_max, '0);
    bus_rd(BASE + 14'd1, s);
    check("abort_shadow", s, 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1;
    model_reset();
    repeat (N + 2) begin
      @(negedge mclk);
      check("abort_no_valid", ucc_valid, 1'b0);
    end
    check_all("abort");

    // Out-of-range accesses
    bus_wr(BASE + 14'(2 * N + 1), 16'hFFFF, 2'b11);
    bus_rd(BASE + 14'(2 * N + 1), s);
    check("oor_read", s, 16'h0000);
    bus_rd(BASE - 14'd1, s);
    check("below_read", s, 16'h0000);
    check_all("oor");

    // Randomized mix
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 99);
      r  = $urandom_range(0, N - 1);
      if (op < 50) begin
        write_region(r, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(1, 3)));
      end else if (op < 65) begin
        check_region(r, 1'($urandom_range(0, 1)));
      end else if (op < 75) begin
        d  = 16'($urandom);
        we = 2'($urandom_range(1, 3));
        if (we == 2'b11 && d[15:8] == KEY && d[0]) d[0] = 1'b0;
        commit(d, we);
      end else if (op < 92) begin
        commit({KEY, 7'($urandom), 1'b1}, 2'b11);
      end else if (op < 97) begin
        check_all("rand");
      end else begin
        apply_reset();
      end
    end
    check_all("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ucc_config_bank.md
Name: ucc_config_bank

Overview:
- Parametrised, run-time-programmable successor to the static UCC definition block.
- Holds N_UCC min/max region pairs in shadow registers written over the openMSP430 peripheral bus.
- On a keyed commit command it validates every pair sequentially, then atomically copies the pairs to the active outputs and locks the bank until reset.
- Active outputs feed the UCC monitors; the status word is readable by software.

Parameters:
- N_UCC, 3, number of UCC regions; legal range 1..16.
- BASE_ADDR, 14'h0C8, word address of the CTRL/STATUS register; region words follow it.
- CMD_KEY, 8'hA5, key required in CTRL[15:8] for a commit.

Ports:
- mclk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access enable.
- per_we  in  2  byte write enables; bit0 = low byte, bit1 = high byte.
- per_dout  out  16  read data; combinational; 0 when not selected.
- ucc_min  out  16*N_UCC  active region minima; region i is bits [16*i +: 16].
- ucc_max  out  16*N_UCC  active region maxima; same packing as ucc_min.
- ucc_valid  out  1  high while the bank is LOCKED.

Behaviour:
- Address map (word offsets from BASE_ADDR):
  - Offset 0: CTRL/STATUS.
  - Offset 2i+1: shadow_min[i]; offset 2i+2: shadow_max[i], for i = 0..N_UCC-1.
  - Select = per_en and offset in 0..2*N_UCC. Addresses outside this range have no effect and read 0.
- Reset (async, reset_n=0): state UNLOCKED; all shadow and active registers 0; ucc_min/ucc_max all 0; ucc_valid 0; STATUS flags 0; index counter 0.
- STATUS read layout:
  - bit0 locked; bit1 busy (VALIDATE); bit2 range_err; bit3 key_err; bit4 wr_viol.
  - bits[11:8] err_idx; all other bits 0.
- Read: per_dout = selected register value when per_en=1 and per_we=0. Zero-latency combinational. Reads have no side effects.
- Shadow writes:
  - Accepted only in UNLOCKED; per_we bits enable their byte lanes independently.
  - In VALIDATE: ignored, no flag.
  - In LOCKED: ignored, and wr_viol is set; wr_viol is sticky until reset.
- CTRL write, UNLOCKED only:
  - Valid commit requires per_we=2'b11, per_din[15:8]=CMD_KEY and per_din[0]=1. It clears range_err, key_err and err_idx, sets idx=0 and enters VALIDATE.
  - Any other CTRL write in UNLOCKED sets key_err and leaves state unchanged.
  - CTRL writes in VALIDATE are ignored; in LOCKED they set wr_viol.
- State machine: UNLOCKED -> VALIDATE -> {LOCKED | UNLOCKED}.
  - Each VALIDATE cycle checks shadow_min[idx] <= shadow_max[idx] (unsigned 16-bit; equality passes).
  - Fail at idx: next edge -> UNLOCKED, range_err=1, err_idx=idx; active registers unchanged.
  - Pass and idx < N_UCC-1: idx increments.
  - Pass and idx == N_UCC-1: next edge copies all shadow pairs to active, state LOCKED, ucc_valid=1, all in the same edge.
  - Commit latency: ucc_valid rises exactly N_UCC edges after the edge that accepted the commit.
- LOCKED is terminal. Only reset_n leaves it. Active outputs never change while LOCKED.
- Reset asserted mid-VALIDATE aborts immediately to the reset state; no partial copy is visible.
- Simultaneous events: a single bus access per cycle, so no arbitration is needed. A shadow write on the commit edge cannot occur, since the same bus cycle can only target one register.
- Active outputs change only on a successful commit edge; never glitch between commits.

Test Plan:
- Reset values: assert reset_n=0 mid-run -> ucc_min/ucc_max=0, ucc_valid=0, STATUS read=16'h0000.
- Good commit, N_UCC=3:
  - Write regions (0x0100,0x01FF), (0x0200,0x0200), (0xE000,0xFFDF), then CTRL=16'hA501.
  - STATUS bit1=1 for 3 cycles; ucc_valid rises on the 3rd edge after the commit edge.
  - ucc_min={E000,0200,0100}; STATUS=16'h0001.
- Range error: set region1 min=0x0300, max=0x02FF, then commit -> returns UNLOCKED after 2 edges, STATUS=16'h0104, ucc_valid=0, outputs still 0.
- Bad key and lock violation:
  - CTRL=16'h5A01 -> STATUS bit3 set, state UNLOCKED.
  - After a good commit, write 0x1234 to region0 min -> ucc_min unchanged, STATUS bit4 set.
  - Reset clears bit4.
- Byte lanes: write 0xAB12 with per_we=2'b01 to shadow_max[2] -> reads 0x0012; then 0xCD00 with per_we=2'b10 -> reads 0xCD12.
- Reset during VALIDATE: commit, drop reset_n on the 2nd VALIDATE cycle -> outputs and shadows 0 asynchronously, ucc_valid never rises.
